// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one ble_uart_tx serializer between NUM_REQ byte-stream
// requesters with packet-granular round-robin arbitration.
// Optional build macro UART_TX_ARB_TAG_EN: every packet goes out prefixed by a
// single tag byte (TAG_BASE | grant id) before its payload.
//
// Handshake: a requester byte transfers on a rising clk_in edge where
// req_valid_in[i] and req_ready_out[i] are both high; a requester must hold
// data/last stable while valid is high and not yet accepted, and ready never
// depends on valid (only on state, grant and tx_busy_in).
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter int         ID_W     = $clog2(NUM_REQ),
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_REQ-1:0]   req_valid_in,
  input  logic [8*NUM_REQ-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]   req_last_in,
  output logic [NUM_REQ-1:0]   req_ready_out,
  output logic                 tx_enable_out,
  output logic [7:0]           tx_data_out,
  input  logic                 tx_busy_in,
  input  logic                 tx_done_in,
  output logic                 grant_valid_out,
  output logic [ID_W-1:0]      grant_id_out,
  output logic                 pkt_done_out,
  output logic [2:0]           dbg_state_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT     = 3'd3
`ifdef UART_TX_ARB_TAG_EN
    ,
    S_TAG      = 3'd4,
    S_TAG_WAIT = 3'd5
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic            last_q;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            accept;
  logic            tx_done_seen;

  // base + k wrapped modulo NUM_REQ (k < NUM_REQ, base < NUM_REQ)
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

`ifndef UART_TX_ARB_TAG_EN
  // Tag base only matters when tag bytes are generated.
  logic unused_tag_base;
  assign unused_tag_base = ^TAG_BASE;
`endif

  assign dbg_state_out = state_q;
  // The done pulse can never belong to the byte being launched this cycle.
  assign tx_done_seen  = tx_done_in && !tx_enable_out;
  assign accept        = req_valid_in[grant_id_out] && req_ready_out[grant_id_out];

  // Round-robin pick: first valid requester at or after the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid_in[wrap_idx(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_id    = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  // Only the owner sees ready, and only while the serializer is free in LOAD.
  always_comb begin
    req_ready_out = '0;
    if (state_q == S_LOAD && !tx_busy_in) req_ready_out[grant_id_out] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (|req_valid_in) state_d = S_ARB;
      S_ARB: begin
        if (!pick_found) state_d = S_IDLE;
`ifdef UART_TX_ARB_TAG_EN
        else             state_d = S_TAG;
`else
        else             state_d = S_LOAD;
`endif
      end
      S_LOAD: if (accept) state_d = S_WAIT;
      S_WAIT: if (tx_done_seen) state_d = last_q ? S_IDLE : S_LOAD;
`ifdef UART_TX_ARB_TAG_EN
      S_TAG:      if (!tx_busy_in) state_d = S_TAG_WAIT;
      S_TAG_WAIT: if (tx_done_seen) state_d = S_LOAD;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, pointer, byte register and one-cycle pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q        <= '0;
      grant_id_out    <= '0;
      grant_valid_out <= 1'b0;
      tx_data_out     <= 8'h00;
      tx_enable_out   <= 1'b0;
      last_q          <= 1'b0;
      pkt_done_out    <= 1'b0;
    end else begin
      tx_enable_out <= 1'b0;
      pkt_done_out  <= 1'b0;
      case (state_q)
        S_ARB: begin
          if (pick_found) begin
            grant_id_out    <= pick_id;
            grant_valid_out <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            tx_data_out   <= req_data_in[8*int'(grant_id_out) +: 8];
            tx_enable_out <= 1'b1;
            last_q        <= req_last_in[grant_id_out];
          end
        end
        S_WAIT: begin
          if (tx_done_seen && last_q) begin
            pkt_done_out    <= 1'b1;
            grant_valid_out <= 1'b0;
            rr_ptr_q        <= wrap_idx(grant_id_out, 1);
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        S_TAG: begin
          if (!tx_busy_in) begin
            tx_data_out   <= TAG_BASE | 8'(grant_id_out);
            tx_enable_out <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one ble_uart_tx serializer between NUM_REQ byte-stream requesters, such as the command responder, telemetry and debug blocks.
- Uses round-robin arbitration at packet granularity: a grant is held from a packet's first byte through the byte flagged last.
- Drives the serializer's enable_in/data_in and sequences bytes using its busy_out/done_out.
- Sits between the requester logic and ble_uart_tx; the uart_tick_generator/ble_uart_tx pair is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the grant index.
- TAG_BASE, 8'hA0, upper bits of the tag byte (used only with the optional feature).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous active-high reset
- req_valid_in  input  NUM_REQ  per-requester byte valid
- req_data_in  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_last_in  input  NUM_REQ  byte is the last of its packet
- req_ready_out  output  NUM_REQ  byte accepted when valid&ready
- tx_enable_out  output  1  one-cycle pulse to ble_uart_tx enable_in
- tx_data_out  output  8  byte to ble_uart_tx data_in
- tx_busy_in  input  1  from ble_uart_tx busy_out
- tx_done_in  input  1  from ble_uart_tx done_out (one-cycle pulse at end of stop bit)
- grant_valid_out  output  1  a packet is in progress
- grant_id_out  output  ID_W  index of the current owner
- pkt_done_out  output  1  one-cycle pulse after the last byte's tx_done_in

Behaviour:
- Reset: state=IDLE, rr pointer=0, and all outputs 0 (ready, enable, data, grant_valid, grant_id, pkt_done).
- IDLE: if any req_valid_in is high, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch grant_id and set grant_valid_out=1; go to LOAD.
  - If no request is valid (withdrawn), return to IDLE.
- LOAD: req_ready_out[grant_id] = !tx_busy_in. It is combinational from state, grant and tx_busy_in; all other ready bits are 0.
  - On acceptance (valid&ready): register the byte into tx_data_out, pulse tx_enable_out on the next cycle, record last, go to WAIT.
  - Latency from acceptance to enable is exactly 1 cycle.
  - tx_data_out holds its value until the next load.
- WAIT:
  - tx_done_in is ignored in the cycle tx_enable_out is high.
  - On a later tx_done_in:
    - If last was not set: go to LOAD.
    - If last was set: pulse pkt_done_out, clear grant_valid_out, set rr pointer=(grant_id+1) mod NUM_REQ, go to IDLE.
- Mid-packet stall: if the owner drops valid in LOAD, the grant is held indefinitely with no timeout. Other requesters see ready=0.
- Simultaneous requests: the lowest index at or after the rr pointer wins. Back-to-back packets from one requester alternate with others, so no starvation.
- Single-byte packet (last=1 on the first byte): goes LOAD→WAIT→IDLE, and the pointer advances.
- Reset mid-packet: the partial packet is abandoned, no pkt_done_out is pulsed, the pointer returns to 0.
- grant_id_out is held after release, until the next ARB.
- Never more than one ready bit is high. tx_enable_out is never asserted while tx_busy_in=1.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Defined:
  - ARB goes to a TAG state that loads TAG_BASE | grant_id (zero-extended) into tx_data_out and pulses tx_enable_out.
  - It then waits for tx_done_in in a TAG_WAIT state before entering LOAD.
  - Each packet on the wire is prefixed by exactly one tag byte. pkt_done_out is unchanged.
- Undefined: no TAG states; the wire carries only payload bytes, and TAG_BASE is unused.

Test Plan:
- Single requester 0 sends 8'h93,8'hC3 (last on C3), with real uart_tick_generator (115200, 16x) and ble_uart_tx → the line shows 93 then C3 LSB-first, one tx_enable_out per byte, one pkt_done_out after the second tx_done_in, grant_id_out=0.
- Requesters 1 and 2 both valid with 2-byte packets from reset → req 1 is served first, then req 2; rr pointer ends at 3; no interleaving of bytes between packets.
- Req 0 sends continuous 1-byte packets while req 3 is valid → grant order is 0,3,0,3; req 3 waits at most one packet.
- Owner deasserts valid for 20000 cycles mid-packet while req 1 is valid → grant held, req_ready_out[1]=0 throughout; transmission resumes with the owner's next byte.
- rst_in pulsed while a byte is in WAIT → all outputs 0 the next cycle; no pkt_done_out; a new packet after reset is granted starting from index 0.
- With UART_TX_ARB_TAG_EN, req 2 sends 8'h55 (last) → wire bytes are A2,55; pkt_done_out pulses once after the 55 byte.
